// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-master RAM arbiter:
//   - default geometry of the shared RAM (ADDR_W, DATA_W, DEPTH)
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - round-robin pick helper
package ram_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Returns the index of the master to grant. last_grant is the master
    // granted most recently; on contention the other one wins. The result
    // is only meaningful when at least one request is high.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/ram_sync.sv
// ram_sync
// Single-port synchronous RAM, DEPTH x DATA_W, read-first.
// Ports:
//   clk      in   clock
//   writeOn  in   write enable (mem[address] <= data_in at the rising edge)
//   address  in   word address
//   data_in  in   write data
//   data_out out  registered read data: mem[address] one clock later
// Contents are never cleared.
module ram_sync #(
    parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W = ram_arbiter_pkg::DATA_W,
    parameter int DEPTH  = ram_arbiter_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              writeOn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeOn) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one ram_sync instance between two masters with round-robin
// arbitration. One access takes three cycles: IDLE (grant + latch command),
// ACCESS (RAM driven from the latched command), RESP (ack + read data).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN  request and command from master N (0/1)
//   gntN                   one-cycle pulse: command accepted
//   ackN                   one-cycle pulse: access complete (2 cycles after gntN)
//   rdataN                 read data, updated in the ackN cycle of a read, held otherwise
module ram_arbiter #(
    parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W = ram_arbiter_pkg::DATA_W,
    parameter int DEPTH  = ram_arbiter_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    import ram_arbiter_pkg::*;

    state_e            state_q, state_d;
    logic              last_q, last_d;      // master granted most recently
    logic              owner_q, owner_d;    // master owning the access in flight
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              grant_valid;
    logic              grant_id;
    logic [1:0]        gnt_v;
    logic [1:0]        ack_v;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 || req1) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Grants, acks and the RAM write strobe are all gated by rst so that a
    // reset cycle neither accepts a command nor completes a pending one.
    always_comb begin
        grant_id    = rr_pick(req0, req1, last_q);
        grant_valid = (state_q == IDLE) && (req0 || req1) && !rst;
        gnt_v       = '0;
        ack_v       = '0;
        if (grant_valid) begin
            gnt_v[grant_id] = 1'b1;
        end
        if ((state_q == RESP) && !rst) begin
            ack_v[owner_q] = 1'b1;
        end
        ram_we = (state_q == ACCESS) && we_q && !rst;
    end

    // ---------------- command latch / round-robin pointer ----------------
    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_valid) begin
            last_d  = grant_id;
            owner_d = grant_id;
            we_d    = grant_id ? we1    : we0;
            addr_d  = grant_id ? addr1  : addr0;
            wdata_d = grant_id ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;    // master 0 wins the first contention
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // ---------------- per-master read data ----------------
    // The RESP cycle passes the RAM output straight through; the register
    // captures it so the value is held until the next read ack.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            always_comb begin
                rdata_d[gi] = rdata_q[gi];
                if (ack_v[gi] && !we_q) begin
                    rdata_d[gi] = ram_dout;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q[gi] <= '0;
                end else begin
                    rdata_q[gi] <= rdata_d[gi];
                end
            end
        end
    endgenerate

    assign gnt0   = gnt_v[0];
    assign gnt1   = gnt_v[1];
    assign ack0   = ack_v[0];
    assign ack1   = ack_v[1];
    assign rdata0 = rdata_d[0];
    assign rdata1 = rdata_d[1];

    // ---------------- shared RAM ----------------
    ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .writeOn  (ram_we),
        .address  (addr_q),
        .data_in  (wdata_q),
        .data_out (ram_dout)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level model: an access granted at cycle n is acked
// at n+2 and the arbiter can grant again at n+3; memory is a plain array.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1;
    logic [31:0] rdata0, rdata1;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .req1   (req1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    int tests = 0;
    int fails = 0;

    // reference model
    logic [31:0] mem_m [32];
    int          age    = 0;     // cycles since the in-flight grant (0 = none)
    bit          last_m = 1'b1;  // master granted most recently
    bit          own_m  = 1'b0;
    bit          we_m   = 1'b0;
    logic [4:0]  addr_m = '0;
    logic [31:0] wdata_m = '0;
    logic [31:0] hold0 = '0, hold1 = '0;
    bit          g_seen0, g_seen1, g_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cycle(input bit rs,
                         input bit q0, input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit q1, input bit w1, input logic [4:0] a1, input logic [31:0] d1);
        logic        eg0, eg1, ea0, ea1;
        logic [31:0] er0, er1;
        bit          gv, winner;
        @(posedge clk);
        #1;
        rst = rs;
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        eg0 = 0; eg1 = 0; ea0 = 0; ea1 = 0;
        er0 = hold0; er1 = hold1;
        gv = 0; winner = 0;
        if (!rs) begin
            if (age == 0 && (q0 || q1)) begin
                gv = 1;
                if (q0 && q1) winner = (last_m == 1'b1) ? 1'b0 : 1'b1;
                else          winner = q1;
                if (winner) eg1 = 1; else eg0 = 1;
            end
            if (age == 2) begin
                if (own_m) ea1 = 1; else ea0 = 1;
                if (!we_m) begin
                    if (own_m) er1 = mem_m[addr_m]; else er0 = mem_m[addr_m];
                end
            end
        end
        g_seen0 = gv && !winner;
        g_seen1 = gv && winner;
        g_id    = winner;
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("ack0", 32'(ack0), 32'(ea0));
        chk("ack1", 32'(ack1), 32'(ea1));
        chk("rdata0", rdata0, er0);
        chk("rdata1", rdata1, er1);
        // state after the coming edge
        if (rs) begin
            age = 0; last_m = 1'b1; hold0 = '0; hold1 = '0;
        end else if (age == 2) begin
            if (!we_m) begin
                if (own_m) hold1 = mem_m[addr_m]; else hold0 = mem_m[addr_m];
            end
            age = 0;
        end else if (age == 1) begin
            if (we_m) mem_m[addr_m] = wdata_m;
            age = 2;
        end else if (gv) begin
            own_m   = winner;
            we_m    = winner ? w1 : w0;
            addr_m  = winner ? a1 : a0;
            wdata_m = winner ? d1 : d0;
            last_m  = winner;
            age     = 1;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Full access by one master: request until granted, then wait for ack.
    task automatic access(input bit m, input bit w, input logic [4:0] a, input logic [31:0] d);
        int  n = 0;
        bit  got = 0;
        while (!got && n < 8) begin
            if (m) cycle(0, 0, 0, '0, '0, 1, w, a, d);
            else   cycle(0, 1, w, a, d, 0, 0, '0, '0);
            got = m ? g_seen1 : g_seen0;
            n++;
        end
        chk("grant_wait", 32'(got), 32'd1);
        idle();
        idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  n;
        bit  p0, p1, first_id, prev_id, have_prev;
        int  gcount;

        repeat (2) @(posedge clk);
        // reset state
        cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);

        // preload every word so the model knows all contents
        for (int a = 0; a < 32; a++) begin
            access(a[0], 1, 5'(a), (a == 7) ? 32'h0 : $urandom);
        end

        // write then read, master 0; ack two cycles after gnt is checked per cycle
        access(0, 1, 5'd5, 32'hDEADBEEF);
        access(0, 0, 5'd5, 32'h0);
        chk("wr_rd_addr5", rdata0, 32'hDEADBEEF);

        // first contention after reset
        cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        p0 = 1; p1 = 1; n = 0; first_id = 1; have_prev = 0;
        while ((p0 || p1) && n < 12) begin
            cycle(0, p0, 0, 5'd3, 32'h0, p1, 1, 5'd3, 32'h12345678);
            if ((g_seen0 || g_seen1) && !have_prev) begin
                first_id = g_id;
                have_prev = 1;
            end
            if (g_seen0) p0 = 0;
            if (g_seen1) p1 = 0;
            n++;
        end
        chk("contend_first", 32'(first_id), 32'd0);
        chk("contend_done", 32'(p0 || p1), 32'd0);
        idle();
        idle();
        access(0, 0, 5'd3, 32'h0);
        chk("contend_rd3", rdata0, 32'h12345678);

        // fairness: both requesting for 12 cycles
        gcount = 0; have_prev = 0; prev_id = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(0, 1, 0, 5'(c), '0, 1, 0, 5'(c + 16), '0);
            if (g_seen0 || g_seen1) begin
                if (have_prev) chk("fair_alternate", 32'(g_id), 32'(!prev_id));
                prev_id = g_id;
                have_prev = 1;
                gcount++;
            end
        end
        chk("fair_count", 32'(gcount), 32'd4);
        idle();
        idle();

        // reset in ACCESS suppresses write and ack
        cycle(0, 0, 0, '0, '0, 1, 1, 5'd7, 32'hAAAA5555);
        chk("rstmid_gnt1", 32'(g_seen1), 32'd1);
        cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle();
        access(1, 0, 5'd7, 32'h0);
        chk("rstmid_rd7", rdata1, 32'h0);

        // address boundary
        access(0, 1, 5'd31, 32'h0000001F);
        access(1, 1, 5'd0, 32'hFFFFFFFF);
        access(1, 0, 5'd31, 32'h0);
        chk("bound_rd31", rdata1, 32'h0000001F);
        access(0, 0, 5'd0, 32'h0);
        chk("bound_rd0", rdata0, 32'hFFFFFFFF);

        // drop and withdraw: req1 pulsed during a master-0 access
        cycle(0, 1, 1, 5'd9, 32'h0BADF00D, 0, 0, '0, '0);
        chk("drop_gnt0", 32'(g_seen0), 32'd1);
        cycle(0, 0, 0, '0, '0, 1, 0, 5'd2, '0);
        idle();
        idle();
        idle();

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 49) == 0),
                  1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 5'($urandom), $urandom);
        end
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
